// File: rtl/mp_ooo_bht_ctr_table_if.sv
// Frontend/commit bus of the pattern history table.
// The master side is the fetch/commit logic, the slave side is the table.
interface mp_ooo_bht_ctr_table_if #(
    parameter int INDEX_WIDTH = 6,
    parameter int GHR_WIDTH   = 6
);
    logic                   init_busy;
    logic                   pred_valid;
    logic [31:0]            pred_pc;
    logic                   pred_resp_valid;
    logic                   pred_taken;
    logic [INDEX_WIDTH-1:0] pred_index;
    logic                   upd_valid;
    logic [INDEX_WIDTH-1:0] upd_index;
    logic                   upd_taken;
    logic                   ghr_restore_valid;
    logic [GHR_WIDTH-1:0]   ghr_restore;
    logic [GHR_WIDTH-1:0]   ghr;

    modport master (
        output pred_valid, pred_pc,
        output upd_valid, upd_index, upd_taken,
        output ghr_restore_valid, ghr_restore,
        input  init_busy, pred_resp_valid, pred_taken, pred_index, ghr
    );

    modport slave (
        input  pred_valid, pred_pc,
        input  upd_valid, upd_index, upd_taken,
        input  ghr_restore_valid, ghr_restore,
        output init_busy, pred_resp_valid, pred_taken, pred_index, ghr
    );
endinterface

// File: rtl/mp_ooo_bht_ctr_table.sv
// Pattern history table of saturating counters for the OoO frontend.
// Fetch looks up a direction prediction (PC or gshare indexed), commit
// trains the counter at the returned index and shifts the committed
// global history. After reset a hardware sweep sets every counter to
// weakly-not-taken before lookups and updates are accepted.
module mp_ooo_bht_ctr_table #(
    parameter int INDEX_WIDTH = 6,
    parameter int CTR_WIDTH   = 2,
    parameter int GHR_WIDTH   = 6,
    parameter int USE_GSHARE  = 1,
    parameter int PC_LSB      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    mp_ooo_bht_ctr_table_if.slave  bus
);

    localparam int ENTRIES = 1 << INDEX_WIDTH;

    // Weakly-not-taken: the largest value whose MSB is still zero.
    localparam logic [CTR_WIDTH-1:0] CTR_WNT = CTR_WIDTH'((2 ** (CTR_WIDTH - 1)) - 1);
    localparam logic [CTR_WIDTH-1:0] CTR_MAX = {CTR_WIDTH{1'b1}};
    localparam logic [CTR_WIDTH-1:0] CTR_MIN = {CTR_WIDTH{1'b0}};
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = {INDEX_WIDTH{1'b1}};

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                 state;
    logic [INDEX_WIDTH-1:0] sweep_ptr;
    logic                   init_busy_q;

    logic [CTR_WIDTH-1:0]   ctr_mem [ENTRIES];

    logic [GHR_WIDTH-1:0]   ghr_q;
    logic [GHR_WIDTH-1:0]   ghr_shift;
    logic [INDEX_WIDTH-1:0] ghr_ext;

    logic                   resp_valid_q;
    logic                   resp_taken_q;
    logic [INDEX_WIDTH-1:0] resp_index_q;

    logic                   run;
    logic                   pred_fire;
    logic                   upd_fire;
    logic [INDEX_WIDTH-1:0] pc_index;
    logic [INDEX_WIDTH-1:0] lookup_index;
    logic [CTR_WIDTH-1:0]   upd_old;
    logic [CTR_WIDTH-1:0]   upd_new;
    logic [CTR_WIDTH-1:0]   lookup_ctr;

    // Only the index field of the PC takes part in the lookup.
    logic                   unused_pc_bits;
    assign unused_pc_bits = ^bus.pred_pc;

    assign run       = (state == ST_RUN);
    assign pred_fire = run && bus.pred_valid;
    assign upd_fire  = run && bus.upd_valid;
    assign pc_index  = bus.pred_pc[PC_LSB +: INDEX_WIDTH];

    // Zero-extend the history to the index width for the gshare fold.
    always_comb begin
        ghr_ext = '0;
        ghr_ext[GHR_WIDTH-1:0] = ghr_q;
    end

    // Lookup index: PC field, optionally folded with the committed history.
    always_comb begin
        lookup_index = pc_index;
        if (USE_GSHARE != 0) begin
            lookup_index = pc_index ^ ghr_ext;
        end
    end

    // Saturating next value for the entry being trained this cycle.
    always_comb begin
        upd_old = ctr_mem[bus.upd_index];
        upd_new = upd_old;
        if (bus.upd_taken) begin
            if (upd_old != CTR_MAX) begin
                upd_new = upd_old + CTR_WIDTH'(1);
            end
        end else begin
            if (upd_old != CTR_MIN) begin
                upd_new = upd_old - CTR_WIDTH'(1);
            end
        end
    end

    // Counter the lookup sees after this edge: a same-edge update to the
    // same entry is forwarded so the response reflects the written value.
    always_comb begin
        lookup_ctr = ctr_mem[lookup_index];
        if (upd_fire && (bus.upd_index == lookup_index)) begin
            lookup_ctr = upd_new;
        end
    end

    // History after shifting in the resolved direction.
    generate
        if (GHR_WIDTH == 1) begin : g_ghr_one
            assign ghr_shift = bus.upd_taken;
        end else begin : g_ghr_wide
            assign ghr_shift = {ghr_q[GHR_WIDTH-2:0], bus.upd_taken};
        end
    endgenerate

    // Init sweep / run state machine with a registered busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_INIT;
            sweep_ptr   <= '0;
            init_busy_q <= 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    sweep_ptr <= sweep_ptr + INDEX_WIDTH'(1);
                    if (sweep_ptr == LAST_INDEX) begin
                        state       <= ST_RUN;
                        init_busy_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    init_busy_q <= 1'b0;
                end
                default: begin
                    state       <= ST_INIT;
                    sweep_ptr   <= '0;
                    init_busy_q <= 1'b1;
                end
            endcase
        end
    end

    // Counter array: sweep writes during init, read-modify-write in run.
    // While reset is held the sweep pointer sits at zero, so the only write
    // is the harmless init value into entry 0.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            ctr_mem[sweep_ptr] <= CTR_WNT;
        end else if (upd_fire) begin
            ctr_mem[bus.upd_index] <= upd_new;
        end
    end

    // Committed global history; a restore wins over the commit shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q <= '0;
        end else if (bus.ghr_restore_valid) begin
            ghr_q <= bus.ghr_restore;
        end else if (upd_fire) begin
            ghr_q <= ghr_shift;
        end
    end

    // Registered prediction response; index and direction hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_taken_q <= 1'b0;
            resp_index_q <= '0;
        end else begin
            resp_valid_q <= pred_fire;
            if (pred_fire) begin
                resp_index_q <= lookup_index;
                resp_taken_q <= lookup_ctr[CTR_WIDTH-1];
            end
        end
    end

    assign bus.init_busy       = init_busy_q;
    assign bus.pred_resp_valid = resp_valid_q;
    assign bus.pred_taken      = resp_taken_q;
    assign bus.pred_index      = resp_index_q;
    assign bus.ghr             = ghr_q;

endmodule

// File: tb/tb_mp_ooo_bht_ctr_table.sv
// Self-checking bench for the pattern history table. Two instances share
// clock and reset: one PC-indexed, one gshare-indexed. A behavioural model
// of the counters and history pushes expected responses into per-instance
// queues when a lookup is driven; they are popped when the response is due.
module tb_mp_ooo_bht_ctr_table;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mp_ooo_bht_ctr_table_if #(.INDEX_WIDTH(6), .GHR_WIDTH(6)) bus_pc ();
    mp_ooo_bht_ctr_table_if #(.INDEX_WIDTH(6), .GHR_WIDTH(6)) bus_gs ();

    mp_ooo_bht_ctr_table #(
        .INDEX_WIDTH(6), .CTR_WIDTH(2), .GHR_WIDTH(6), .USE_GSHARE(0), .PC_LSB(2)
    ) dut_pc (
        .clk(clk),
        .rst(rst),
        .bus(bus_pc.slave)
    );

    mp_ooo_bht_ctr_table #(
        .INDEX_WIDTH(6), .CTR_WIDTH(2), .GHR_WIDTH(6), .USE_GSHARE(1), .PC_LSB(2)
    ) dut_gs (
        .clk(clk),
        .rst(rst),
        .bus(bus_gs.slave)
    );

    typedef struct packed {
        logic        pv;
        logic [31:0] pc;
        logic        uv;
        logic [5:0]  ui;
        logic        ut;
        logic        rv;
        logic [5:0]  rval;
    } stim_t;

    typedef struct packed {
        logic [5:0] idx;
        logic       taken;
    } exp_t;

    stim_t      st [2];
    int         mctr [2][64];
    logic [5:0] mghr [2];
    int         sweep [2];
    exp_t       q0 [$];
    exp_t       q1 [$];

    int checks   = 0;
    int failures = 0;
    int n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic setStim(input int k, input logic pv, input logic [31:0] pc,
                           input logic uv, input logic [5:0] ui, input logic ut,
                           input logic rv, input logic [5:0] rval);
        st[k].pv   = pv;
        st[k].pc   = pc;
        st[k].uv   = uv;
        st[k].ui   = ui;
        st[k].ut   = ut;
        st[k].rv   = rv;
        st[k].rval = rval;
    endtask

    task automatic driveBus();
        bus_pc.pred_valid        = st[0].pv;
        bus_pc.pred_pc           = st[0].pc;
        bus_pc.upd_valid         = st[0].uv;
        bus_pc.upd_index         = st[0].ui;
        bus_pc.upd_taken         = st[0].ut;
        bus_pc.ghr_restore_valid = st[0].rv;
        bus_pc.ghr_restore       = st[0].rval;
        bus_gs.pred_valid        = st[1].pv;
        bus_gs.pred_pc           = st[1].pc;
        bus_gs.upd_valid         = st[1].uv;
        bus_gs.upd_index         = st[1].ui;
        bus_gs.upd_taken         = st[1].ut;
        bus_gs.ghr_restore_valid = st[1].rv;
        bus_gs.ghr_restore       = st[1].rval;
    endtask

    // Behavioural effect of one clock edge on instance k (1 = gshare).
    task automatic modelEdge(input int k);
        exp_t       e;
        logic [5:0] idx;
        if (rst) begin
            sweep[k] = 64;
            mghr[k]  = 6'd0;
            for (int i = 0; i < 64; i++) mctr[k][i] = 1;
            if (k == 0) q0.delete(); else q1.delete();
            return;
        end
        if (sweep[k] > 0) begin
            sweep[k]--;
            if (st[k].rv) mghr[k] = st[k].rval;
            return;
        end
        idx = st[k].pc[7:2] ^ ((k == 1) ? mghr[k] : 6'd0);
        if (st[k].uv) begin
            if (st[k].ut && mctr[k][st[k].ui] < 3) mctr[k][st[k].ui]++;
            else if (!st[k].ut && mctr[k][st[k].ui] > 0) mctr[k][st[k].ui]--;
        end
        if (st[k].rv) mghr[k] = st[k].rval;
        else if (st[k].uv) mghr[k] = {mghr[k][4:0], st[k].ut};
        if (st[k].pv) begin
            e.idx   = idx;
            e.taken = (mctr[k][idx] >= 2);
            if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic checkInst(input int k, input string nm, input logic busy,
                             input logic [5:0] g, input logic rv,
                             input logic [5:0] pidx, input logic tk);
        exp_t e;
        logic have;
        have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
        chk({nm, "_init_busy"}, busy, (sweep[k] > 0));
        chk({nm, "_ghr"}, g, mghr[k]);
        chk({nm, "_resp_valid"}, rv, have);
        if (have) begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk({nm, "_pred_index"}, pidx, e.idx);
            chk({nm, "_pred_taken"}, tk, e.taken);
        end
    endtask

    task automatic checkOutput();
        checkInst(0, "pc", bus_pc.init_busy, bus_pc.ghr, bus_pc.pred_resp_valid,
                  bus_pc.pred_index, bus_pc.pred_taken);
        checkInst(1, "gs", bus_gs.init_busy, bus_gs.ghr, bus_gs.pred_resp_valid,
                  bus_gs.pred_index, bus_gs.pred_taken);
    endtask

    // Drive the staged stimulus across one edge, then check both instances.
    task automatic applyStimulus();
        driveBus();
        modelEdge(0);
        modelEdge(1);
        @(posedge clk);
        #1;
        st[0] = '0;
        st[1] = '0;
        driveBus();
        checkOutput();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        st[0] = '0;
        st[1] = '0;
        sweep[0] = 64;
        sweep[1] = 64;
        mghr[0] = 6'd0;
        mghr[1] = 6'd0;
        rst = 1'b1;
        driveBus();
        #2;
        chk("rst_pred_index", bus_gs.pred_index, 6'd0);
        chk("rst_pred_taken", bus_gs.pred_taken, 1'b0);
        chk("rst_init_busy", bus_gs.init_busy, 1'b1);
        applyStimulus();
        applyStimulus();

        // Release reset and measure the sweep length.
        $display("[TB] init sweep");
        rst = 1'b0;
        n = 0;
        do begin
            applyStimulus();
            n++;
        end while (bus_gs.init_busy && n < 100);
        chk("sweep_len", n, 64);

        // Fresh table predicts not-taken at index 0.
        $display("[TB] first lookup");
        setStim(1, 1'b1, 32'h100, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
        applyStimulus();
        chk("t1_index", bus_gs.pred_index, 6'd0);
        chk("t1_taken", bus_gs.pred_taken, 1'b0);

        // PC-indexed training and saturation at index 5.
        $display("[TB] saturation");
        setStim(0, 1'b0, 32'h0, 1'b1, 6'd5, 1'b1, 1'b0, 6'd0); applyStimulus();
        setStim(0, 1'b0, 32'h0, 1'b1, 6'd5, 1'b1, 1'b0, 6'd0); applyStimulus();
        setStim(0, 1'b1, 32'h14, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0); applyStimulus();
        chk("t2_taken_sat", bus_pc.pred_taken, 1'b1);
        chk("t2_index", bus_pc.pred_index, 6'd5);
        setStim(0, 1'b0, 32'h0, 1'b1, 6'd5, 1'b1, 1'b0, 6'd0); applyStimulus();
        setStim(0, 1'b0, 32'h0, 1'b1, 6'd5, 1'b0, 1'b0, 6'd0); applyStimulus();
        setStim(0, 1'b0, 32'h0, 1'b1, 6'd5, 1'b0, 1'b0, 6'd0); applyStimulus();
        setStim(0, 1'b1, 32'h14, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0); applyStimulus();
        chk("t2_taken_after_dec", bus_pc.pred_taken, 1'b0);

        // Same-edge update and lookup of index 9 sees the written value.
        $display("[TB] write-then-read");
        setStim(0, 1'b1, 32'h24, 1'b1, 6'd9, 1'b1, 1'b0, 6'd0); applyStimulus();
        chk("t3_fwd_taken", bus_pc.pred_taken, 1'b1);

        // Gshare history and index folding.
        $display("[TB] gshare history");
        setStim(1, 1'b0, 32'h0, 1'b1, 6'd0, 1'b1, 1'b0, 6'd0); applyStimulus();
        setStim(1, 1'b0, 32'h0, 1'b1, 6'd0, 1'b0, 1'b0, 6'd0); applyStimulus();
        setStim(1, 1'b0, 32'h0, 1'b1, 6'd0, 1'b1, 1'b0, 6'd0); applyStimulus();
        chk("t4_ghr", bus_gs.ghr, 6'b000101);
        setStim(1, 1'b1, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0); applyStimulus();
        chk("t4_index", bus_gs.pred_index, 6'd5);

        // Restore beats the shift on the same edge.
        $display("[TB] ghr restore");
        setStim(1, 1'b0, 32'h0, 1'b1, 6'd0, 1'b1, 1'b1, 6'b111000); applyStimulus();
        chk("t5_ghr_restore", bus_gs.ghr, 6'b111000);

        // Mixed traffic on both instances.
        $display("[TB] mixed traffic");
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 2; k++) begin
                setStim(k, 1'($urandom_range(0, 1)), $urandom,
                        1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                        6'($urandom_range(0, 63)));
            end
            applyStimulus();
        end

        // Saturate index 3 of the gshare table before the re-sweep.
        $display("[TB] reset mid-run");
        for (int i = 0; i < 3; i++) begin
            setStim(1, 1'b0, 32'h0, 1'b1, 6'd3, 1'b1, 1'b0, 6'd0);
            applyStimulus();
        end
        setStim(1, 1'b1, {24'd0, 6'd3 ^ mghr[1], 2'b00}, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
        applyStimulus();
        chk("t6_pre_taken", bus_gs.pred_taken, 1'b1);
        chk("t6_pre_index", bus_gs.pred_index, 6'd3);

        rst = 1'b1;
        applyStimulus();
        applyStimulus();
        rst = 1'b0;
        n = 0;
        do begin
            setStim(0, 1'b1, $urandom, 1'b1, 6'd7, 1'b1, 1'b0, 6'd0);
            setStim(1, 1'b1, $urandom, 1'b1, 6'd3, 1'b1, 1'b0, 6'd0);
            applyStimulus();
            n++;
        end while (bus_gs.init_busy && n < 100);
        chk("t6_sweep_len", n, 64);
        setStim(1, 1'b1, 32'h0C, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
        applyStimulus();
        chk("t6_post_index", bus_gs.pred_index, 6'd3);
        chk("t6_post_taken", bus_gs.pred_taken, 1'b0);
        applyStimulus();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
